pkg_rr_arb: RTL
===============

PKG_RR_ARB -- requirements
Module: pkg_rr_arb

Interface
REQ-001 Parameter NUM_CH, default 8: number of requesting channels; RTL and bench are exercised only at 8.
REQ-002 Parameter WDOG_LIMIT, default 2047: cycles allowed in a packet before abort; used only under the macro in REQ-024.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ch_req  in  8  per-channel request, held until ack is seen.
REQ-006 ch_qos  in  8  per-channel priority: 1 = high, 0 = low; sampled with ch_req.
REQ-007 ch_data  in  64  packed 8x8 channel bytes; channel i uses bits [8i+7:8i].
REQ-008 ch_sop / ch_eop  in  8 each  per-channel packet first/last byte marks.
REQ-009 ch_ack  out  8  one-hot grant, registered.
REQ-010 out_data  out  8  byte of the granted channel.
REQ-011 out_vld / out_sop / out_eop  out  1 each  valid byte, first byte and last byte on the output.
REQ-012 out_qos  out  1  latched priority of the current grant.
REQ-013 out_ch_id  out  3  index of the granted channel.

Function
REQ-014 The FSM SHALL have two states:
- IDLE: no grant.
- BUSY: one channel holds ch_ack.
REQ-015 Arbitration when entering BUSY:
- Candidate set is all high-priority requesters (ch_req & ch_qos) if any exist, else all low-priority requesters.
- The winner is the first set bit at or after rr_ptr, searching circularly upward.
REQ-016 IDLE -> BUSY when ch_req != 0:
- ch_ack = onehot(winner) from the next cycle.
- out_qos and out_ch_id are latched in the same cycle.
REQ-017 In BUSY, ch_ack SHALL stay constant until and including the cycle in which ch_eop[gnt] = 1; a requester dropping ch_req mid-packet does not release the grant.
REQ-018 In BUSY, the outputs SHALL follow the granted channel combinationally:
- out_data = ch_data[gnt], out_sop = ch_sop[gnt], out_eop = ch_eop[gnt].
- out_vld = 1 every BUSY cycle.
REQ-019 In IDLE: out_data = 0, out_vld = out_sop = out_eop = 0.
REQ-020 On the eop cycle:
- rr_ptr <= gnt + 1, mod 8 (7 wraps to 0).
- If other requests are pending, or the granted channel still requests, re-arbitrate using the new rr_ptr and issue the next ack the following cycle (back-to-back, no bubble).
- Otherwise go to IDLE.
REQ-021 A high-priority request arriving mid-packet SHALL NOT preempt; it wins at the next arbitration.
REQ-022 Within a priority class no requester SHALL wait more than 7 packets from that class.

Reset
REQ-023 While rst_n = 0:
- FSM state = IDLE, rr_ptr = 0, ch_ack = 0.
- out_qos = 0, out_ch_id = 0.
- All data, valid and mark outputs = 0.
- A packet in flight is discarded with no eop emitted.

Configuration
REQ-024 Macro PKG_RR_ARB_WDOG_EN, when defined, enables the packet watchdog:
- An 11-bit counter clears on each grant and increments every BUSY cycle.
- When it reaches WDOG_LIMIT, the block forces out_eop = 1 for that cycle, releases the grant as in REQ-020, and sets a sticky output wdog_err (1 bit, cleared only by reset).
REQ-025 Without PKG_RR_ARB_WDOG_EN, the counter and the wdog_err port do not exist, and the grant is held indefinitely until eop.

Structure
REQ-026 A shared package pkg_rr_arb_pkg SHALL hold:
- the state enum (IDLE, BUSY);
- NUM_CH;
- CH_ID_W = 3;
- the default WDOG_LIMIT.
REQ-027 The circular priority search SHALL be a sub-module rr_pick, with inputs req[7:0] and ptr[2:0] and outputs onehot[7:0], id[2:0] and any.

Verification
REQ-028 Reset, then ch_req = 8'h00 for 10 cycles -> ch_ack = 0, out_vld = 0, state IDLE.
REQ-029 ch_req = 8'h81 low, rr_ptr = 0, 3-byte packets -> ack 8'h01 first, then 8'h80 back-to-back, then 8'h01; out_ch_id sequence 0, 7, 0.
REQ-030 ch_req = 8'h0F, ch_qos = 8'h08 -> ack 8'h08 first; then 8'h01, 8'h02, 8'h04 in order.
REQ-031 Channel 2 holding a 5-byte packet, channel 5 asserts with qos = 1 at byte 2 -> ack 8'h04 stays through eop; ack 8'h20 the next cycle.
REQ-032 Assert rst_n = 0 during byte 3 of a packet -> ch_ack = 0 and out_vld = 0 immediately; the first grant after reset follows rr_ptr = 0.
REQ-033 With PKG_RR_ARB_WDOG_EN and WDOG_LIMIT = 16, a grant with no eop -> forced out_eop at BUSY cycle 16, wdog_err = 1, grant moves on.

Source files
------------

// File: rtl/pkg_rr_arb_pkg.sv
// Shared definitions for the packet round-robin arbiter: the arbiter state
// encoding, channel count, channel-id width and the default watchdog limit.
// The optional watchdog is compiled in with the macro PKG_RR_ARB_WDOG_EN.
package pkg_rr_arb_pkg;

    localparam int NUM_CH          = 8;
    localparam int CH_ID_W         = 3;
    localparam int WDOG_LIMIT_DFLT = 2047;
    localparam int WDOG_W          = 11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Round-robin pointer advance; the id width makes 7 wrap to 0.
    function automatic logic [CH_ID_W-1:0] next_ptr(input logic [CH_ID_W-1:0] id);
        return id + CH_ID_W'(1);
    endfunction

endpackage

// File: rtl/pkg_rr_arb_rr_pick.sv
// Circular first-set search: returns the first asserted request at or after
// ptr, scanning upward and wrapping from the top channel back to channel 0.
module rr_pick
    import pkg_rr_arb_pkg::*;
(
    input  logic [NUM_CH-1:0]  req,
    input  logic [CH_ID_W-1:0] ptr,
    output logic [NUM_CH-1:0]  onehot,
    output logic [CH_ID_W-1:0] id,
    output logic               any
);

    // Requests rotated so that bit 0 is the channel sitting at ptr.
    logic [NUM_CH-1:0]  rot;
    logic [CH_ID_W-1:0] off;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
            assign rot[gi] = req[CH_ID_W'(ptr + CH_ID_W'(gi))];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the distance from ptr to the winner.
    always_comb begin
        off = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = CH_ID_W'(k);
            end
        end
    end

    assign any    = |req;
    assign id     = ptr + off;
    assign onehot = any ? (NUM_CH'(1) << id) : '0;

endmodule

// File: rtl/pkg_rr_arb.sv
// Packet round-robin arbiter with two priority classes. A grant is held for a
// whole packet (until the granted channel's eop) and the next grant is issued
// back-to-back on the eop cycle when any request is pending.
// Optional feature: define PKG_RR_ARB_WDOG_EN to add a per-packet watchdog
// that forces an eop after WDOG_LIMIT busy cycles and raises sticky wdog_err.
module pkg_rr_arb #(
    parameter int NUM_CH     = pkg_rr_arb_pkg::NUM_CH,
    parameter int WDOG_LIMIT = pkg_rr_arb_pkg::WDOG_LIMIT_DFLT
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CH-1:0]                  ch_req,
    input  logic [NUM_CH-1:0]                  ch_qos,
    input  logic [8*NUM_CH-1:0]                ch_data,
    input  logic [NUM_CH-1:0]                  ch_sop,
    input  logic [NUM_CH-1:0]                  ch_eop,
    output logic [NUM_CH-1:0]                  ch_ack,
    output logic [7:0]                         out_data,
    output logic                               out_vld,
    output logic                               out_sop,
    output logic                               out_eop,
    output logic                               out_qos,
    output logic [pkg_rr_arb_pkg::CH_ID_W-1:0] out_ch_id
`ifdef PKG_RR_ARB_WDOG_EN
    ,
    output logic                               wdog_err
`endif
);

    import pkg_rr_arb_pkg::*;

    arb_state_e         state_q, state_d;
    logic [CH_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [NUM_CH-1:0]  ack_q, ack_d;
    logic               qos_q, qos_d;

    logic               busy;
    logic [NUM_CH-1:0]  hi_req;
    logic               hi_any;
    logic [NUM_CH-1:0]  cand;
    logic               pkt_end;
    logic               load;
    logic               wdog_hit;

    logic [CH_ID_W-1:0] pick_ptr;
    logic [CH_ID_W-1:0] pick_id;
    logic [NUM_CH-1:0]  pick_onehot;
    logic               pick_any;

    assign busy = (state_q == BUSY);

    // High-priority requesters form the candidate set whenever any exist.
    assign hi_req = ch_req & ch_qos;
    assign hi_any = |hi_req;
    assign cand   = hi_any ? hi_req : ch_req;

    // The packet ends on the granted channel's eop or on a watchdog expiry.
    assign pkt_end = busy && (ch_eop[gnt_id_q] || wdog_hit);

    // Re-arbitration on the eop cycle already uses the advanced pointer so the
    // next grant can follow with no idle cycle in between.
    assign pick_ptr = pkt_end ? next_ptr(gnt_id_q) : rr_ptr_q;
    assign load     = pick_any && (!busy || pkt_end);

    rr_pick u_pick (
        .req    (cand),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .id     (pick_id),
        .any    (pick_any)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave IDLE on any request, return only when a packet
    // ends with nothing left to grant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = BUSY;
            BUSY:    if (pkt_end && !pick_any) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant bookkeeping: pointer advances on packet end, a new winner is latched on load.
    always_comb begin
        ack_d    = ack_q;
        gnt_id_d = gnt_id_q;
        qos_d    = qos_q;
        rr_ptr_d = rr_ptr_q;
        if (pkt_end) begin
            rr_ptr_d = next_ptr(gnt_id_q);
            ack_d    = '0;
        end
        if (load) begin
            ack_d    = pick_onehot;
            gnt_id_d = pick_id;
            qos_d    = hi_any;
        end
    end

    // Grant registers; reset discards any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            gnt_id_q <= '0;
            ack_q    <= '0;
            qos_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            gnt_id_q <= gnt_id_d;
            ack_q    <= ack_d;
            qos_q    <= qos_d;
        end
    end

    // Output mux: the granted channel's byte and marks pass straight through while busy.
    always_comb begin
        out_vld  = busy;
        out_data = '0;
        out_sop  = 1'b0;
        out_eop  = 1'b0;
        if (busy) begin
            out_data = ch_data[{gnt_id_q, 3'b000} +: 8];
            out_sop  = ch_sop[gnt_id_q];
            out_eop  = pkt_end;
        end
    end

    assign ch_ack    = ack_q;
    assign out_qos   = qos_q;
    assign out_ch_id = gnt_id_q;

`ifdef PKG_RR_ARB_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;

    // Counter value is the zero-based busy cycle index of the current grant.
    assign wdog_hit = busy && (wdog_cnt_q == WDOG_LAST);

    // Watchdog next state: restart on each grant, count while busy, error is sticky.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (load) begin
            wdog_cnt_d = '0;
        end else if (busy) begin
            wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
        end
        wdog_err_d = wdog_err_q | wdog_hit;
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    assign wdog_hit = 1'b0;
`endif

endmodule
